// File: rtl/nsa_pkg.sv
// nsa_pkg: shared state type, nibble width and counter-width helper for nibble_serial_adder
package nsa_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_t;
    localparam int NIB_W = 4;
    function automatic int clog2(input int v);
        int r = 1;
        for (int i = 1; i < 32; i++) r = ((1 << i) < v) ? i + 1 : r;
        return r;
    endfunction
endpackage

// File: rtl/nsa_nibble_add4.sv
// nsa_nibble_add4: combinational 4-bit carry-select adder slice
//   a, b : nibble operands
//   ci   : carry in, selects between the two precomputed sums
//   s    : nibble sum
//   co   : carry out
module nsa_nibble_add4
    import nsa_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
);
    logic [NIB_W:0] s0, s1;
    assign s0 = {1'b0, a} + {1'b0, b};
    assign s1 = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, 1'b1};
    assign {co, s} = ci ? s1 : s0;
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that adds one nibble per clock through a carry-select slice
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b, cin           : operands and carry-in, latched on acceptance
//   out_valid, out_ready: result handshake
//   sum, cout           : registered result and carry out of bit WIDTH-1
//   busy                : high in RUN or DONE
//   ovf                 : signed overflow, present only when NSA_OVF_EN is defined
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef NSA_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);
    localparam int NIBS = WIDTH / NIB_W;
    localparam int CW = clog2(NIBS);

    nsa_state_t             st;
    logic [WIDTH-1:0]       opa, opb, nxt;
    logic [WIDTH-NIB_W-1:0] res;
    logic [CW-1:0]          cnt;
    logic                   c, co;
    logic [NIB_W-1:0]       s;

    nsa_nibble_add4 u_add (.a(opa[NIB_W-1:0]), .b(opb[NIB_W-1:0]), .ci(c), .s(s), .co(co));

    assign in_ready = st == IDLE;
    assign busy     = st != IDLE;
    // New nibble enters at the top; after the last nibble nxt is the full sum.
    assign nxt      = {s, res};

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            cnt       <= '0;
            c         <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            res       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef NSA_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (st)
                IDLE: if (in_valid) begin
                    opa <= a;
                    opb <= b;
                    c   <= cin;
                    cnt <= '0;
                    st  <= RUN;
                end
                RUN: begin
                    opa <= {{NIB_W{1'b0}}, opa[WIDTH-1:NIB_W]};
                    opb <= {{NIB_W{1'b0}}, opb[WIDTH-1:NIB_W]};
                    res <= nxt[WIDTH-1:NIB_W];
                    c   <= co;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NIBS - 1)) begin
                        st        <= DONE;
                        out_valid <= 1'b1;
                        sum       <= nxt;
                        cout      <= co;
`ifdef NSA_OVF_EN
                        // opa/opb now hold the top nibble, so bit 3 is the operand MSB.
                        ovf       <= opa[NIB_W-1] ^ opb[NIB_W-1] ^ s[NIB_W-1] ^ co;
`endif
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    st        <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: scoreboard bench for nibble_serial_adder against an arithmetic model
module tb_nibble_serial_adder;
    localparam int W = 16;
    localparam int NIBS = W / 4;

    logic clk = 0, rst = 1, in_valid = 0, cin = 0, out_ready = 0;
    logic [W-1:0] a = 0, b = 0;
    logic in_ready, out_valid, cout, busy, ovf_w;
    logic [W-1:0] sum;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout),
`ifdef NSA_OVF_EN
        .ovf(ovf_w),
`endif
        .busy(busy)
    );
`ifndef NSA_OVF_EN
    assign ovf_w = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [W:0] r;
        logic       ov;
        longint     t;
    } exp_t;

    exp_t q[$];
    int checks = 0, passes = 0;
    int or_mode = 0;
    bit fresh = 1;

    function automatic void check(input string n, input longint got, input longint exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, got, exp, $time);
    endfunction

    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        exp_t e;
        longint unsigned t;
        t = longint'(ia) + longint'(ib) + longint'(ic);
        e.r = t[W:0];
        e.ov = (ia[W-1] == ib[W-1]) && (e.r[W-1] != ia[W-1]);
        e.t = 0;
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        exp_t e;
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        else begin
            a = ia; b = ib; cin = ic; in_valid = 1;
            @(posedge clk);
            e = model(ia, ib, ic);
            e.t = $time;
            q.push_back(e);
            #1;
            in_valid = 0;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
    endtask

    initial forever begin
        @(posedge clk); #2;
        out_ready = (or_mode == 2) ? 1'($urandom_range(0, 1)) : (or_mode == 1);
    end

    initial forever begin
        @(negedge clk);
        if (rst) fresh = 1;
        else if (out_valid) begin
            if (q.size() == 0) check("unexpected_result", out_valid, 0);
            else begin
                if (fresh) check("latency", (($time - q[0].t) - 5) / 10, NIBS);
                check("sum", sum, q[0].r[W-1:0]);
                check("cout", cout, q[0].r[W]);
                check("busy_done", busy, 1);
`ifdef NSA_OVF_EN
                check("ovf", ovf_w, q[0].ov);
`endif
                if (out_ready) begin
                    void'(q.pop_front());
                    fresh = 1;
                end else fresh = 0;
            end
        end
    end

    initial begin
        int lo, n;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_busy", busy, 0);
`ifdef NSA_OVF_EN
        check("rst_ovf", ovf_w, 0);
`endif
        @(posedge clk); #1;
        or_mode = 1;
        issue(16'hFFFF, 16'h0001, 0);
        issue(16'h1234, 16'h4321, 1);
        lo = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
            lo++;
        end
        check("in_ready_low_cycles", lo, NIBS + 1);
        @(posedge clk); #1;
        or_mode = 0;
        issue(16'h00FF, 16'h0F0F, 0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", out_valid, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        or_mode = 1;
        @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_after", in_ready, 1);
        check("bp_out_valid_after", out_valid, 0);
        check("bp_sum_kept", sum, 16'h100E);
        check("bp_cout_kept", cout, 0);
        @(posedge clk); #1;
        issue(16'h1111, 16'h2222, 0);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; a = 16'hAAAA; b = 16'h5555; cin = 1;
            check("in_ready_run", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 0;
        issue(16'hAAAA, 16'h5555, 1);
        issue(16'h1234, 16'h4321, 0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        q.delete();
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_busy", busy, 0);
        @(posedge clk); #1;
        issue(16'h0001, 16'h0001, 0);
        issue(16'h7FFF, 16'h0001, 0);
        issue(16'h8000, 16'h8000, 0);
        or_mode = 2;
        repeat (40) issue(W'($urandom), W'($urandom), 1'($urandom));
        or_mode = 1;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain", q.size(), 0);
        @(negedge clk);
        check("final_idle", in_ready, 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
